hwpf_stride_rpt: RTL
====================

// Module: hwpf_stride_rpt
// PURPOSE
//  Parametrised reference-prediction-table (RPT) stride prefetcher for the HPDcache.
//  Snoops demand loads (PC tag + byte address) and trains a fully-associative, LRU-replaced table of per-PC strides.
//  Once a stride is confirmed, an issue engine emits DEGREE prefetch addresses on a valid/ready port toward the HPDcache request arbiter.
// PARAMETERS
//  NENTRIES     16  table entries (power of 2, >=2)
//  TAG_W        39  PC tag width
//  ADDR_W       64  byte address width
//  STRIDE_W     12  signed stride width (bytes)
//  CONF_THRESH   3  consecutive stride matches to reach STEADY (1..7)
//  MAX_DEGREE    4  max prefetches per trigger (1..15)
//  PAGE_W       12  log2 page size; prefetches never cross a page
// PORTS
//  clk_i         in   1          clock
//  rst_i         in   1          synchronous reset, active high
//  enable_i      in   1          0: no training, no new triggers
//  degree_i      in   4          prefetches per trigger, clamped to [1,MAX_DEGREE]
//  snoop_valid_i in   1          demand load observed (always accepted)
//  snoop_tag_i   in   TAG_W      PC tag of load
//  snoop_addr_i  in   ADDR_W     byte address of load
//  pf_valid_o    out  1          prefetch request valid
//  pf_ready_i    in   1          prefetch request accepted
//  pf_addr_o     out  ADDR_W     prefetch byte address
//  busy_o        out  1          issue engine active
// BEHAVIOUR
//  Reset: all entries invalid, ages 0; pf_valid_o=0, pf_addr_o=0, busy_o=0, engine IDLE.
//  Lookup combinational on snoop_*; table/engine update on same clk edge (snoop_valid_i & enable_i).
//  Miss: allocate lowest-index invalid entry, else max-age entry; state=INIT, last_addr=addr, stride=0, conf=0.
//  Hit: delta = addr - last_addr; last_addr<=addr always. Per-entry FSM (rpt_state_t):
//   INIT   -> TRAIN, stride<=delta, conf=0.
//   TRAIN  delta==stride & stride!=0: conf++; conf reaching CONF_THRESH -> STEADY. Mismatch: stride<=delta, conf=0.
//   STEADY delta==stride: stay, raise trigger. Mismatch: -> TRAIN, stride<=delta, conf=0.
//   delta not representable in signed STRIDE_W: entry -> INIT (stride=0, conf=0).
//  Stride 0 never reaches STEADY. LRU: accessed/allocated entry age=0; entries younger than its old age ++ (ages stay a permutation of valid entries).
//  Trigger: engine IDLE -> ISSUE with base=addr, stride, cnt=clamped degree; pf_valid_o rises next cycle.
//   Trigger while engine ISSUE: dropped, no preemption.
//  Issue: pf_addr_o=base+stride (sign-extended); stable while pf_valid_o & !pf_ready_i.
//   On handshake: base<=pf_addr_o, cnt--; cnt==1 -> IDLE next cycle.
//  Page guard: next address differs from snoop addr in bits [ADDR_W-1:PAGE_W] -> never valid, engine -> IDLE.
//  enable_i=0: table frozen; engine finishes the burst in progress.
//  rst_i mid-burst: pf_valid_o=0 next cycle, burst lost, table cleared.
// CONFIGURATION
//  HWPF_RPT_STATS_EN defined: adds outputs stat_trig_o, stat_issued_o, stat_drop_o (32b each, wrapping).
//   Counts triggers accepted, handshakes, and triggers dropped (busy or page-guard); cleared by rst_i.
//  Not defined: the three ports and their counters are absent; behaviour otherwise identical.
// STRUCTURE
//  hwpf_stride_pkg: rpt_state_t enum {RPT_INIT, RPT_TRAIN, RPT_STEADY}, rpt_issue_state_t {IDLE, ISSUE}, default localparams.
//  Entry struct is parameter-dependent; declare it locally (valid, tag, last_addr, stride, conf, state, age).
//  Sub-module hwpf_stride_rpt_issue: engine FSM, page guard, valid/ready; table and LRU in top.
// TESTING
//  1 Tag 0x10, addrs 0x1000,+0x40 x5, degree 2, ready=1 -> no pf until 5th load (0x1140);
//    then pf 0x1180, 0x11C0 on consecutive cycles.
//  2 Same tag stride 0x40, then 0x1300 after 0x11C0 -> state TRAIN, no trigger;
//    stride 0x140 needs CONF_THRESH matches to re-arm.
//  3 Base 0x1F80, stride 0x40, degree 4 -> pf 0x1FC0 only; 0x2000 suppressed, busy_o falls.
//  4 pf_ready_i=0 for 5 cycles -> pf_addr_o stable, pf_valid_o held;
//    second trigger in that window dropped (stat_drop_o=1 with HWPF_RPT_STATS_EN).
//  5 NENTRIES+1 distinct tags, then retouch tag 0 -> tag 0 evicted, reallocated in INIT, no pf.
//  6 rst_i asserted mid-burst -> next cycle pf_valid_o=0, busy_o=0; repeating scenario 1 gives identical pf sequence.

Source files
------------

// File: rtl/hwpf_stride_pkg.sv
// Shared types and defaults for the RPT stride prefetcher (hwpf_stride_rpt).
// Optional statistics counters are enabled with the HWPF_RPT_STATS_EN macro in the top.
package hwpf_stride_pkg;

    typedef enum logic [1:0] {
        RPT_INIT,
        RPT_TRAIN,
        RPT_STEADY
    } rpt_state_t;

    typedef enum logic {
        IDLE,
        ISSUE
    } rpt_issue_state_t;

    localparam int HWPF_NENTRIES    = 16;
    localparam int HWPF_TAG_W       = 39;
    localparam int HWPF_ADDR_W      = 64;
    localparam int HWPF_STRIDE_W    = 12;
    localparam int HWPF_CONF_THRESH = 3;
    localparam int HWPF_MAX_DEGREE  = 4;
    localparam int HWPF_PAGE_W      = 12;

    // A requested degree of zero still issues one prefetch.
    function automatic logic [3:0] clamp_degree(input logic [3:0] deg, input logic [3:0] max_deg);
        if (deg == 4'd0) return 4'd1;
        if (deg > max_deg) return max_deg;
        return deg;
    endfunction

endpackage

// File: rtl/hwpf_stride_rpt_issue.sv
// Prefetch issue engine: walks base+stride DEGREE times over a valid/ready port,
// stopping early rather than crossing a page boundary.
module hwpf_stride_rpt_issue
    import hwpf_stride_pkg::*;
#(
    parameter int ADDR_W     = HWPF_ADDR_W,
    parameter int STRIDE_W   = HWPF_STRIDE_W,
    parameter int PAGE_W     = HWPF_PAGE_W,
    parameter int MAX_DEGREE = HWPF_MAX_DEGREE
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                trig_i,
    input  logic [ADDR_W-1:0]   trig_addr_i,
    input  logic [STRIDE_W-1:0] trig_stride_i,
    input  logic [3:0]          degree_i,
    input  logic                pf_ready_i,
    output logic                pf_valid_o,
    output logic [ADDR_W-1:0]   pf_addr_o,
    output logic                busy_o,
    output logic                trig_acc_o,
    output logic                trig_drop_o
);

    function automatic logic [ADDR_W-1:0] sext(input logic [STRIDE_W-1:0] s);
        return {{(ADDR_W-STRIDE_W){s[STRIDE_W-1]}}, s};
    endfunction

    function automatic logic same_page(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b);
        return a[ADDR_W-1:PAGE_W] == b[ADDR_W-1:PAGE_W];
    endfunction

    rpt_issue_state_t    state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [STRIDE_W-1:0] stride_q, stride_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   trig_nxt, run_nxt;

    assign trig_nxt = trig_addr_i + sext(trig_stride_i);
    assign run_nxt  = addr_q + sext(stride_q);

    // addr_q always holds the address currently offered, so the page check is
    // done one step ahead and an out-of-page address is never presented.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        stride_d    = stride_q;
        cnt_d       = cnt_q;
        trig_acc_o  = 1'b0;
        trig_drop_o = 1'b0;
        case (state_q)
            IDLE: begin
                if (trig_i) begin
                    if (same_page(trig_nxt, trig_addr_i)) begin
                        state_d    = ISSUE;
                        addr_d     = trig_nxt;
                        stride_d   = trig_stride_i;
                        cnt_d      = clamp_degree(degree_i, 4'(MAX_DEGREE));
                        trig_acc_o = 1'b1;
                    end else begin
                        trig_drop_o = 1'b1;
                    end
                end
            end
            ISSUE: begin
                trig_drop_o = trig_i;
                if (pf_ready_i) begin
                    if (cnt_q == 4'd1 || !same_page(run_nxt, addr_q)) begin
                        state_d = IDLE;
                    end else begin
                        addr_d = run_nxt;
                        cnt_d  = cnt_q - 4'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        stride_q <= stride_d;
    end

    assign pf_valid_o = (state_q == ISSUE);
    assign busy_o     = (state_q == ISSUE);
    assign pf_addr_o  = addr_q;

endmodule

// File: rtl/hwpf_stride_rpt.sv
// RPT stride prefetcher top: fully-associative per-PC stride table with LRU replacement.
// Define HWPF_RPT_STATS_EN to add stat_trig_o / stat_issued_o / stat_drop_o counters.
module hwpf_stride_rpt
    import hwpf_stride_pkg::*;
#(
    parameter int NENTRIES    = HWPF_NENTRIES,
    parameter int TAG_W       = HWPF_TAG_W,
    parameter int ADDR_W      = HWPF_ADDR_W,
    parameter int STRIDE_W    = HWPF_STRIDE_W,
    parameter int CONF_THRESH = HWPF_CONF_THRESH,
    parameter int MAX_DEGREE  = HWPF_MAX_DEGREE,
    parameter int PAGE_W      = HWPF_PAGE_W
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              enable_i,
    input  logic [3:0]        degree_i,
    input  logic              snoop_valid_i,
    input  logic [TAG_W-1:0]  snoop_tag_i,
    input  logic [ADDR_W-1:0] snoop_addr_i,
    output logic              pf_valid_o,
    input  logic              pf_ready_i,
    output logic [ADDR_W-1:0] pf_addr_o,
    output logic              busy_o
`ifdef HWPF_RPT_STATS_EN
    ,
    output logic [31:0]       stat_trig_o,
    output logic [31:0]       stat_issued_o,
    output logic [31:0]       stat_drop_o
`endif
);

    localparam int AGE_W = $clog2(NENTRIES);

    typedef struct packed {
        logic                valid;
        logic [TAG_W-1:0]    tag;
        logic [ADDR_W-1:0]   last_addr;
        logic [STRIDE_W-1:0] stride;
        logic [2:0]          conf;
        rpt_state_t          state;
        logic [AGE_W-1:0]    age;
    } rpt_entry_t;

    rpt_entry_t tbl_q [NENTRIES];
    rpt_entry_t tbl_d [NENTRIES];

    logic              hit, inv_found, do_upd, trig;
    logic [AGE_W-1:0]  hit_idx, inv_idx, lru_idx, sel_idx;
    logic [AGE_W:0]    old_age;
    rpt_entry_t        cur, upd;
    logic [ADDR_W-1:0] delta, stride_ext;
    logic              delta_fits, stride_match;
    logic [2:0]        conf_inc;
    logic              trig_acc, trig_drop;

    assign do_upd = snoop_valid_i & enable_i;

    // Descending scan so the lowest matching index wins.
    always_comb begin
        hit       = 1'b0;
        hit_idx   = '0;
        inv_found = 1'b0;
        inv_idx   = '0;
        lru_idx   = '0;
        for (int i = NENTRIES - 1; i >= 0; i--) begin
            if (tbl_q[i].valid && tbl_q[i].tag == snoop_tag_i) begin
                hit     = 1'b1;
                hit_idx = AGE_W'(i);
            end
            if (!tbl_q[i].valid) begin
                inv_found = 1'b1;
                inv_idx   = AGE_W'(i);
            end
            if (tbl_q[i].valid && tbl_q[i].age == AGE_W'(NENTRIES - 1)) lru_idx = AGE_W'(i);
        end
    end

    // An invalid entry counts as older than every valid one, so all valid ages shift up.
    always_comb begin
        if (hit) begin
            sel_idx = hit_idx;
            old_age = {1'b0, tbl_q[hit_idx].age};
        end else if (inv_found) begin
            sel_idx = inv_idx;
            old_age = (AGE_W+1)'(NENTRIES);
        end else begin
            sel_idx = lru_idx;
            old_age = {1'b0, tbl_q[lru_idx].age};
        end
        cur = tbl_q[sel_idx];
    end

    assign delta        = snoop_addr_i - cur.last_addr;
    assign delta_fits   = (&delta[ADDR_W-1:STRIDE_W-1]) | ~(|delta[ADDR_W-1:STRIDE_W-1]);
    assign stride_ext   = {{(ADDR_W-STRIDE_W){cur.stride[STRIDE_W-1]}}, cur.stride};
    assign stride_match = (delta == stride_ext);
    assign conf_inc     = cur.conf + 3'd1;

    always_comb begin
        upd           = cur;
        trig          = 1'b0;
        upd.age       = '0;
        upd.last_addr = snoop_addr_i;
        if (!hit) begin
            upd.valid  = 1'b1;
            upd.tag    = snoop_tag_i;
            upd.stride = '0;
            upd.conf   = '0;
            upd.state  = RPT_INIT;
        end else if (!delta_fits) begin
            upd.state  = RPT_INIT;
            upd.stride = '0;
            upd.conf   = '0;
        end else begin
            case (cur.state)
                RPT_INIT: begin
                    upd.state  = RPT_TRAIN;
                    upd.stride = delta[STRIDE_W-1:0];
                    upd.conf   = '0;
                end
                RPT_TRAIN: begin
                    if (stride_match && cur.stride != '0) begin
                        upd.conf = conf_inc;
                        if (conf_inc == 3'(CONF_THRESH)) upd.state = RPT_STEADY;
                    end else begin
                        upd.stride = delta[STRIDE_W-1:0];
                        upd.conf   = '0;
                    end
                end
                RPT_STEADY: begin
                    if (stride_match) begin
                        trig = do_upd;
                    end else begin
                        upd.state  = RPT_TRAIN;
                        upd.stride = delta[STRIDE_W-1:0];
                        upd.conf   = '0;
                    end
                end
                default: upd.state = RPT_INIT;
            endcase
        end
    end

    always_comb begin
        tbl_d = tbl_q;
        if (do_upd) begin
            for (int i = 0; i < NENTRIES; i++) begin
                if (AGE_W'(i) == sel_idx) begin
                    tbl_d[i] = upd;
                end else if (tbl_q[i].valid && {1'b0, tbl_q[i].age} < old_age) begin
                    tbl_d[i].age = tbl_q[i].age + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NENTRIES; i++) begin
                tbl_q[i].valid <= 1'b0;
                tbl_q[i].age   <= '0;
                tbl_q[i].state <= RPT_INIT;
                tbl_q[i].conf  <= '0;
            end
        end else begin
            tbl_q <= tbl_d;
        end
    end

    hwpf_stride_rpt_issue #(
        .ADDR_W     (ADDR_W),
        .STRIDE_W   (STRIDE_W),
        .PAGE_W     (PAGE_W),
        .MAX_DEGREE (MAX_DEGREE)
    ) u_issue (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .trig_i        (trig),
        .trig_addr_i   (snoop_addr_i),
        .trig_stride_i (cur.stride),
        .degree_i      (degree_i),
        .pf_ready_i    (pf_ready_i),
        .pf_valid_o    (pf_valid_o),
        .pf_addr_o     (pf_addr_o),
        .busy_o        (busy_o),
        .trig_acc_o    (trig_acc),
        .trig_drop_o   (trig_drop)
    );

`ifdef HWPF_RPT_STATS_EN
    logic [31:0] stat_trig_q, stat_issued_q, stat_drop_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stat_trig_q   <= '0;
            stat_issued_q <= '0;
            stat_drop_q   <= '0;
        end else begin
            stat_trig_q   <= stat_trig_q + 32'(trig_acc);
            stat_issued_q <= stat_issued_q + 32'(pf_valid_o & pf_ready_i);
            stat_drop_q   <= stat_drop_q + 32'(trig_drop);
        end
    end

    assign stat_trig_o   = stat_trig_q;
    assign stat_issued_o = stat_issued_q;
    assign stat_drop_o   = stat_drop_q;
`else
    logic unused_stats;
    assign unused_stats = trig_acc ^ trig_drop;
`endif

endmodule
